// File: rtl/stft_frame_sched.sv
// stft_frame_sched: frame scheduler in front of the WIN_LUT windowing stage.
// It buffers a continuous complex sample stream in a circular buffer. Each time
// WIN_LEN samples are buffered, it emits one N_FFT-long frame (window samples
// plus zero padding) over a valid/ready handshake. It then advances the frame
// start by HOP_LEN.
// Optional build macro STFT_SCHED_CENTER_PAD_EN places (N_FFT-WIN_LEN)/2 zeros
// ahead of the window instead of putting all padding after it.
module stft_frame_sched #(
    parameter int WIDTH   = 16,
    parameter int N_FFT   = 512,
    parameter int WIN_LEN = 480,
    parameter int HOP_LEN = 160,
    parameter int DEPTH   = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_en,
    input  logic [WIDTH-1:0]         din_re,
    input  logic [WIDTH-1:0]         din_im,
    output logic                     fout_valid,
    input  logic                     fout_ready,
    output logic [WIDTH-1:0]         fout_re,
    output logic [WIDTH-1:0]         fout_im,
    output logic [$clog2(N_FFT)-1:0] fout_idx,
    output logic                     fout_sof,
    output logic                     fout_eof,
    output logic [15:0]              frame_cnt,
    output logic                     ovf,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_FFT);
    localparam int AW    = $clog2(DEPTH);
    // Pointers carry one extra bit so that wp-fs can represent a full buffer.
    localparam int PW    = AW + 1;
`ifdef STFT_SCHED_CENTER_PAD_EN
    localparam int PRE   = (N_FFT - WIN_LEN) / 2;
    typedef enum logic [1:0] {IDLE, PREPAD, SEND, PAD} state_t;
`else
    localparam int PRE   = 0;
    typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;
`endif

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wp, fs, occ;
    logic               wr_ok, xfer;
    state_t             state, ld_state;
    logic [IDX_W-1:0]   ld_idx;
    logic [AW-1:0]      rd_addr;
    logic               in_win;
    logic signed [WIDTH-1:0] ld_re, ld_im;

    // Occupancy counts from the frame start. The current window therefore
    // cannot be overwritten until its eof moves fs forward.
    assign occ   = wp - fs;
    assign wr_ok = din_en && (occ != PW'(DEPTH));
    assign xfer  = fout_valid && fout_ready;

    // Index to be loaded next: 0 when starting a frame, otherwise the successor.
    assign ld_idx  = (state == IDLE) ? '0 : fout_idx + 1'b1;
    assign in_win  = (int'(ld_idx) >= PRE) && (int'(ld_idx) < PRE + WIN_LEN);
    assign rd_addr = fs[AW-1:0] + AW'(int'(ld_idx) - PRE);

    // Select the data and region state for the sample about to be loaded.
    always_comb begin
        ld_state = PAD;
        ld_re    = '0;
        ld_im    = '0;
        if (in_win) begin
            ld_state       = SEND;
            {ld_re, ld_im} = mem[rd_addr];
        end
`ifdef STFT_SCHED_CENTER_PAD_EN
        else if (int'(ld_idx) < PRE) begin
            ld_state = PREPAD;
        end
`endif
    end

    // Sample storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp[AW-1:0]] <= {din_re, din_im};
        end
    end

    // Write pointer, frame start and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            fs  <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (din_en && !wr_ok) begin
                ovf <= 1'b1;
            end
            if (xfer && fout_eof) begin
                fs <= fs + PW'(HOP_LEN);
            end
        end
    end

    // Frame FSM with the registered output stage. Returning to IDLE after eof
    // forces a one-cycle gap before the next sof.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fout_valid <= 1'b0;
            fout_re    <= '0;
            fout_im    <= '0;
            fout_idx   <= '0;
            fout_sof   <= 1'b0;
            fout_eof   <= 1'b0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
        end else begin
            if ((state == IDLE && occ >= PW'(WIN_LEN)) ||
                (state != IDLE && xfer && !fout_eof)) begin
                state      <= ld_state;
                fout_valid <= 1'b1;
                fout_re    <= ld_re;
                fout_im    <= ld_im;
                fout_idx   <= ld_idx;
                fout_sof   <= (ld_idx == '0);
                fout_eof   <= (ld_idx == IDX_W'(N_FFT - 1));
                busy       <= 1'b1;
            end else if (state != IDLE && xfer && fout_eof) begin
                state      <= IDLE;
                fout_valid <= 1'b0;
                fout_sof   <= 1'b0;
                fout_eof   <= 1'b0;
                frame_cnt  <= frame_cnt + 16'd1;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stft_frame_sched.sv
// tb_stft_frame_sched: directed bench for stft_frame_sched. A transfer monitor
// checks every transferred sample against the expected frame contents.
module tb_stft_frame_sched;

    localparam int WIDTH   = 16;
    localparam int N_FFT   = 512;
    localparam int WIN_LEN = 480;
    localparam int HOP_LEN = 160;
    localparam int DEPTH   = 1024;
`ifdef STFT_SCHED_CENTER_PAD_EN
    localparam int PRE = (N_FFT - WIN_LEN) / 2;
`else
    localparam int PRE = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              din_en = 1'b0;
    logic [WIDTH-1:0]  din_re = '0;
    logic [WIDTH-1:0]  din_im = '0;
    logic              fout_ready = 1'b1;
    logic              fout_valid;
    logic [WIDTH-1:0]  fout_re, fout_im;
    logic [8:0]        fout_idx;
    logic              fout_sof, fout_eof;
    logic [15:0]       frame_cnt;
    logic              ovf, busy;

    stft_frame_sched #(
        .WIDTH(WIDTH), .N_FFT(N_FFT), .WIN_LEN(WIN_LEN),
        .HOP_LEN(HOP_LEN), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .din_en(din_en), .din_re(din_re), .din_im(din_im),
        .fout_valid(fout_valid), .fout_ready(fout_ready),
        .fout_re(fout_re), .fout_im(fout_im), .fout_idx(fout_idx),
        .fout_sof(fout_sof), .fout_eof(fout_eof), .frame_cnt(frame_cnt),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected real part of frame sample idx for a frame starting at sample value base.
    function automatic logic [15:0] exp_re(input int base, input int idx);
        if (idx >= PRE && idx < PRE + WIN_LEN) return 16'(base + idx - PRE);
        return 16'd0;
    endfunction

    // Transfer monitor state
    int          mon_idx    = 0;
    int          mon_base   = 0;
    int          mon_frames = 0;
    int          rst_base   = 0;
    logic [15:0] sof_re [8];
    logic        hold_pend  = 1'b0;
    logic        after_eof  = 1'b0;
    logic [15:0] hold_re;
    logic [8:0]  hold_idx;
    logic [15:0] e_re, e_im;

    always @(negedge clk) begin
        if (rst) begin
            mon_idx    = 0;
            mon_base   = rst_base;
            mon_frames = 0;
            hold_pend  = 1'b0;
            after_eof  = 1'b0;
        end else begin
            if (after_eof) begin
                check_val("gap_after_eof", 32'(fout_valid), 32'd0);
                after_eof = 1'b0;
            end
            if (hold_pend) begin
                check_val("hold_idx", 32'(fout_idx), 32'(hold_idx));
                check_val("hold_re", 32'(fout_re), 32'(hold_re));
                hold_pend = 1'b0;
            end
            if (fout_valid && !fout_ready) begin
                hold_pend = 1'b1;
                hold_idx  = fout_idx;
                hold_re   = fout_re;
            end
            if (fout_valid && fout_ready) begin
                e_re = exp_re(mon_base, mon_idx);
                e_im = -e_re;
                check_val("xfer_idx", 32'(fout_idx), 32'(mon_idx));
                check_val("xfer_sof", 32'(fout_sof), 32'(mon_idx == 0));
                check_val("xfer_eof", 32'(fout_eof), 32'(mon_idx == N_FFT - 1));
                check_val("xfer_re", 32'(fout_re), 32'(e_re));
                check_val("xfer_im", 32'(fout_im), 32'(e_im));
                if (mon_idx == 0 && mon_frames < 8) sof_re[mon_frames] = fout_re;
                mon_idx++;
                if (mon_idx == N_FFT) begin
                    mon_idx   = 0;
                    mon_base += HOP_LEN;
                    mon_frames++;
                    after_eof = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_en = 1'b0;
        fout_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic send(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            din_en = 1'b1;
            din_re = 16'(start + i);
            din_im = 16'(-(start + i));
            step();
        end
        din_en = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int c = 0;
        while (frame_cnt != 16'(n) && c < budget) begin
            step();
            c++;
        end
        check_val(tag, 32'(frame_cnt), 32'(n));
    endtask

    task automatic wait_idx(input int idx, input int budget);
        int c = 0;
        while (!(fout_valid && fout_idx == 9'(idx)) && c < budget) begin
            step();
            c++;
        end
        check_val("wait_idx", 32'(fout_idx), 32'(idx));
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;

        // Reset state
        #1;
        check_val("rst_valid", 32'(fout_valid), 32'd0);
        check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_idx", 32'(fout_idx), 32'd0);
        check_val("rst_sof_eof", 32'({fout_sof, fout_eof}), 32'd0);

        // Single frame from 480 samples
        do_reset();
        send(480, 0);
        check_val("t1_valid_pre", 32'(fout_valid), 32'd0);
        step();
        check_val("t1_valid_rise", 32'(fout_valid), 32'd1);
        check_val("t1_sof", 32'(fout_sof), 32'd1);
        check_val("t1_idx0", 32'(fout_idx), 32'd0);
        check_val("t1_busy", 32'(busy), 32'd1);
        wait_frames(1, 700, "t1_frame_cnt");
        check_val("t1_frames_seen", 32'(mon_frames), 32'd1);
        check_val("t1_ovf", 32'(ovf), 32'd0);

        // Continuous 800-sample stream gives three hopped frames
        do_reset();
        send(800, 0);
        wait_frames(3, 3000, "t2_frame_cnt");
        repeat (600) step();
        check_val("t2_frame_cnt_final", 32'(frame_cnt), 32'd3);
        check_val("t2_frames_seen", 32'(mon_frames), 32'd3);
        check_val("t2_sof_re_f2", 32'(sof_re[1]), 32'd160);
        check_val("t2_sof_re_f3", 32'(sof_re[2]), 32'd320);
        check_val("t2_ovf", 32'(ovf), 32'd0);
        check_val("t2_busy", 32'(busy), 32'd0);

        // Back-pressure pattern 1,0,0,1 mid-frame
        do_reset();
        send(480, 0);
        repeat (100) step();
        for (int c = 0; c < 4000 && frame_cnt != 16'd1; c++) begin
            fout_ready = pat[c % 4];
            step();
        end
        fout_ready = 1'b1;
        check_val("t3_frame_cnt", 32'(frame_cnt), 32'd1);
        check_val("t3_frames_seen", 32'(mon_frames), 32'd1);
        check_val("t3_idx_after", 32'(mon_idx), 32'd0);

        // Long stall with sustained input: buffer fills, overflow is flagged
        do_reset();
        fout_ready = 1'b0;
        send(2000, 0);
        check_val("t4_ovf", 32'(ovf), 32'd1);
        check_val("t4_valid_held", 32'(fout_valid), 32'd1);
        check_val("t4_idx_held", 32'(fout_idx), 32'd0);
        check_val("t4_re_held", 32'(fout_re), 32'(exp_re(0, 0)));
        fout_ready = 1'b1;
        wait_frames(4, 4000, "t4_frame_cnt");
        repeat (600) step();
        check_val("t4_frame_cnt_final", 32'(frame_cnt), 32'd4);
        check_val("t4_sof_re_f4", 32'(sof_re[3]), 32'(exp_re(480, PRE)));
        check_val("t4_busy", 32'(busy), 32'd0);
        check_val("t4_ovf_sticky", 32'(ovf), 32'd1);

        // Reset in the middle of a frame
        send(96, 1024);
        wait_idx(200, 700);
        #1;
        rst_base = 3000;
        rst = 1'b1;
        #1;
        check_val("t5_valid_async", 32'(fout_valid), 32'd0);
        check_val("t5_frame_cnt_async", 32'(frame_cnt), 32'd0);
        check_val("t5_ovf_async", 32'(ovf), 32'd0);
        check_val("t5_busy_async", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        send(480, 3000);
        wait_frames(1, 700, "t5_frame_cnt");
        check_val("t5_frames_seen", 32'(mon_frames), 32'd1);
        check_val("t5_sof_re", 32'(sof_re[0]), 32'(exp_re(3000, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
